add_accumulator: RTL and testbench

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

---
 rtl/add_accumulator_pkg.sv | 15 +
 rtl/add_accumulator_if.sv | 39 +++
 rtl/add_accumulator_add_core.sv | 23 ++
 rtl/add_accumulator.sv | 104 ++++++++++
 tb/tb_add_accumulator.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_accumulator_pkg.sv
// Shared types and helpers for the batch add accumulator.
package add_accumulator_pkg;

  // Collecting operands, or holding a finished batch result.
  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Width of a counter that must represent 0..count inclusive.
  function automatic int count_width(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/add_accumulator_if.sv
// Operand and result handshake bundle for add_accumulator.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. The producer holds valid and its payload until that edge.
// The consumer may assert ready independently of valid. Neither side may make
// ready depend combinationally on valid.
interface add_accumulator_if
  import add_accumulator_pkg::*;
#(
  parameter int N     = 4,
  parameter int COUNT = 4
) ();

  localparam int CW = count_width(COUNT);

  logic          in_op_valid;
  logic [N-1:0]  in_data;
  logic          out_op_ready;
  logic          in_clear;
  logic          out_res_valid;
  logic          in_res_ready;
  logic [N-1:0]  out_sum;
  logic          out_carry;
  logic          out_overflow;
  logic [CW-1:0] out_count;

  // Accumulator side.
  modport slave (
    input  in_op_valid, in_data, in_clear, in_res_ready,
    output out_op_ready, out_res_valid, out_sum, out_carry, out_overflow, out_count
  );

  // Environment side: operand producer and result consumer.
  modport master (
    output in_op_valid, in_data, in_clear, in_res_ready,
    input  out_op_ready, out_res_valid, out_sum, out_carry, out_overflow, out_count
  );

endinterface

// File: rtl/add_accumulator_add_core.sv
// N-bit adder producing the wrapped sum, unsigned carry-out and signed overflow.
module add_core #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         c,
  output logic         ovf
);

  logic [N:0] wide;

  // Carry is bit N of the widened sum; overflow when equal-signed operands
  // produce a result of the other sign.
  always_comb begin
    wide = {1'b0, a} + {1'b0, b};
    s    = wide[N-1:0];
    c    = wide[N];
    ovf  = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
  end

endmodule

// File: rtl/add_accumulator.sv
// Batch accumulator: sums COUNT operands, tracking sticky carry and signed
// overflow, then holds the result until it is taken downstream.
module add_accumulator
  import add_accumulator_pkg::*;
#(
  parameter int N     = 4,
  parameter int COUNT = 4
) (
  input  logic   in_clk,
  input  logic   in_rst_n,
  add_accumulator_if.slave bus,
  output state_t dbg_state
);

  localparam int CW = count_width(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  state_t        state;
  logic [N-1:0]  acc;
  logic          carry;
  logic          overflow;
  logic [CW-1:0] count;
  logic          op_ready;
  logic          res_valid;

  logic [N-1:0]  add_s;
  logic          add_c;
  logic          add_ovf;

  add_core #(.N(N)) u_add_core (
    .a   (acc),
    .b   (bus.in_data),
    .s   (add_s),
    .c   (add_c),
    .ovf (add_ovf)
  );

  // FSM, datapath registers and registered handshake outputs. Clear beats
  // both operand acceptance and the result handshake. Ready is held low in
  // reset and rises on the first edge after it, so acceptance is keyed off
  // the registered ready rather than the state alone.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state     <= ACC;
      acc       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else if (bus.in_clear) begin
      state     <= ACC;
      acc       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          op_ready <= 1'b1;
          if (bus.in_op_valid && op_ready) begin
            acc      <= add_s;
            carry    <= carry | add_c;
            overflow <= overflow | add_ovf;
            count    <= count + 1'b1;
            if (count == LAST) begin
              state     <= DONE;
              op_ready  <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.in_res_ready) begin
            state     <= ACC;
            acc       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACC;
          op_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // All outputs come straight from registers.
  assign bus.out_op_ready  = op_ready;
  assign bus.out_res_valid = res_valid;
  assign bus.out_sum       = acc;
  assign bus.out_carry     = carry;
  assign bus.out_overflow  = overflow;
  assign bus.out_count     = count;
  assign dbg_state         = state;

endmodule

// File: tb/tb_add_accumulator.sv
// Self-checking bench for add_accumulator (N=4, COUNT=4).
module tb_add_accumulator;
  import add_accumulator_pkg::*;

  localparam int N     = 4;
  localparam int COUNT = 4;
  localparam int CW    = count_width(COUNT);

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] ops [COUNT];
  logic [N-1:0] exp_sum;
  logic         exp_carry;
  logic         exp_ovf;

  add_accumulator_if #(.N(N), .COUNT(COUNT)) bus ();

  add_accumulator #(.N(N), .COUNT(COUNT)) dut (
    .in_clk    (clk),
    .in_rst_n  (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand list.
  task automatic model_batch();
    int u;
    int sv;
    int so;
    u = 0;
    exp_carry = 1'b0;
    exp_ovf   = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      sv = (u >= (1 << (N - 1))) ? u - (1 << N) : u;
      so = (ops[i] >= (1 << (N - 1))) ? int'(ops[i]) - (1 << N) : int'(ops[i]);
      if (u + int'(ops[i]) >= (1 << N)) exp_carry = 1'b1;
      if ((sv + so) > ((1 << (N - 1)) - 1) || (sv + so) < -(1 << (N - 1))) exp_ovf = 1'b1;
      u = (u + int'(ops[i])) % (1 << N);
    end
    exp_sum = N'(u);
  endtask

  task automatic set_ops(input int a, input int b, input int c, input int d);
    ops[0] = N'(a);
    ops[1] = N'(b);
    ops[2] = N'(c);
    ops[3] = N'(d);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus.out_op_ready !== 1'b1 || bus.out_res_valid !== 1'b0 || bus.out_count !== '0 ||
        bus.out_sum !== '0 || bus.out_carry !== 1'b0 || bus.out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s: ready=%b valid=%b count=%0d sum=%h c=%b o=%b, required ready=1 valid=0 all zero",
               name, bus.out_op_ready, bus.out_res_valid, bus.out_count, bus.out_sum,
               bus.out_carry, bus.out_overflow);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus.out_op_ready !== 1'b0 || bus.out_res_valid !== 1'b0 || bus.out_count !== '0 ||
        bus.out_sum !== '0 || bus.out_carry !== 1'b0 || bus.out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s: ready=%b valid=%b count=%0d sum=%h c=%b o=%b, required all zero",
               name, bus.out_op_ready, bus.out_res_valid, bus.out_count, bus.out_sum,
               bus.out_carry, bus.out_overflow);
    end
  endtask

  task automatic check_result(input string name);
    checks++;
    if (bus.out_res_valid !== 1'b1 || bus.out_op_ready !== 1'b0 || bus.out_sum !== exp_sum ||
        bus.out_carry !== exp_carry || bus.out_overflow !== exp_ovf ||
        bus.out_count !== CW'(COUNT)) begin
      failures++;
      $display("FAIL %s: valid=%b ready=%b sum=%h c=%b o=%b count=%0d, required valid=1 ready=0 sum=%h c=%b o=%b count=%0d",
               name, bus.out_res_valid, bus.out_op_ready, bus.out_sum, bus.out_carry,
               bus.out_overflow, bus.out_count, exp_sum, exp_carry, exp_ovf, COUNT);
    end
  endtask

  // Feed ops[0..n-1]; optional random idle gaps. Checks count after each accept.
  task automatic feed(input int n, input bit gaps);
    int budget;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) step();
      end
      bus.in_op_valid = 1'b1;
      bus.in_data     = ops[i];
      budget = 20;
      while (bus.out_op_ready !== 1'b1 && budget > 0) begin
        step();
        budget--;
      end
      checks++;
      if (budget == 0) begin
        failures++;
        $display("FAIL feed_ready_timeout: ready=%b, required 1 within 20 cycles", bus.out_op_ready);
      end
      step();
      bus.in_op_valid = 1'b0;
      bus.in_data     = N'($urandom);
      checks++;
      if (bus.out_count !== CW'(i + 1)) begin
        failures++;
        $display("FAIL feed_count: count=%0d, required %0d", bus.out_count, i + 1);
      end
    end
  endtask

  // Hold res_ready low for 'delay' cycles with result stable, then take it.
  task automatic take_result(input string name, input int delay);
    for (int d = 0; d < delay; d++) begin
      bus.in_op_valid = 1'b1;
      bus.in_data     = N'($urandom);
      step();
      check_result({name, "_hold"});
    end
    bus.in_op_valid  = 1'b0;
    bus.in_res_ready = 1'b1;
    step();
    bus.in_res_ready = 1'b0;
    check_idle({name, "_taken"});
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.in_op_valid  = 1'b0;
    bus.in_data      = '0;
    bus.in_clear     = 1'b0;
    bus.in_res_ready = 1'b0;
    repeat (3) step();
    check_all_zero("reset_state");
    checks++;
    if (dbg_state !== ACC) begin
      failures++;
      $display("FAIL reset_fsm: state=%0d, required ACC", dbg_state);
    end
    rst_n = 1'b1;
    step();
    check_idle("ready_after_reset");
  endtask

  task automatic test_directed();
    set_ops(1, 2, 3, 4);
    feed(COUNT, 1'b0);
    model_batch();
    checks++;
    if (exp_sum !== 4'hA || exp_carry !== 1'b0 || exp_ovf !== 1'b1) begin
      failures++;
      $display("FAIL model_1234: sum=%h c=%b o=%b, required a/0/1", exp_sum, exp_carry, exp_ovf);
    end
    check_result("batch_1234");
    take_result("batch_1234", 0);

    set_ops(8, 8, 1, 1);
    feed(COUNT, 1'b0);
    model_batch();
    check_result("batch_8811");
    take_result("batch_8811", 0);
  endtask

  task automatic test_hold();
    set_ops(1, 1, 1, 1);
    feed(COUNT, 1'b0);
    model_batch();
    check_result("hold_1111");
    take_result("hold_1111", 3);
  endtask

  task automatic test_clear();
    set_ops(3, 5, 0, 0);
    feed(2, 1'b0);
    bus.in_op_valid = 1'b1;
    bus.in_data     = 4'd7;
    bus.in_clear    = 1'b1;
    step();
    bus.in_op_valid = 1'b0;
    bus.in_clear    = 1'b0;
    check_idle("clear_in_acc");
    set_ops(1, 1, 1, 1);
    feed(COUNT, 1'b0);
    model_batch();
    check_result("after_clear");
    // Clear while holding a result, coincident with res_ready: result discarded.
    bus.in_clear     = 1'b1;
    bus.in_res_ready = 1'b1;
    step();
    bus.in_clear     = 1'b0;
    bus.in_res_ready = 1'b0;
    check_idle("clear_in_done");
  endtask

  task automatic test_async_reset();
    set_ops(5, 6, 0, 0);
    feed(2, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_mid_batch");
    step();
    rst_n = 1'b1;
    step();
    check_idle("release_mid_batch");

    set_ops(7, 7, 7, 7);
    feed(COUNT, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_in_done");
    step();
    rst_n = 1'b1;
    step();
    check_idle("release_in_done");

    set_ops(2, 2, 2, 2);
    feed(COUNT, 1'b0);
    model_batch();
    check_result("batch_2222");
    take_result("batch_2222", 1);
  endtask

  task automatic test_random();
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < COUNT; i++) ops[i] = N'($urandom);
      feed(COUNT, 1'b1);
      model_batch();
      check_result("random_batch");
      take_result("random_batch", $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
